// File: rtl/uart_byte_fifo_pkg.sv
// Shared widths, defaults and helpers for the UART byte buffer and pacer.
package uart_byte_fifo_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned FRAME_BITS_DEF = 10;
  localparam int unsigned CLKDIV_DEF     = 32;
  localparam int unsigned DEPTH_DEF      = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int unsigned gap_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_byte_fifo_if.sv
// Byte stream and status bundle between uart_rx, the byte buffer and uart_tx.
interface uart_byte_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  import uart_byte_fifo_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  byte_t            in_data;
  logic             in_valid;
  byte_t            out_data;
  logic             out_send;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;

  // Producer / observer side (uart_rx + uart_tx wiring).
  modport master (
    output in_data, in_valid,
    input  out_data, out_send, count, empty, full, overflow
  );

  // Buffer side.
  modport slave (
    input  in_data, in_valid,
    output out_data, out_send, count, empty, full, overflow
  );

endinterface

// File: rtl/uart_byte_fifo_sync_fifo.sv
// Power-of-two synchronous FIFO with an explicit occupancy register.
// The caller decides push/pop legality; this block just executes them.
module uart_byte_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push_i) wp_d = wp_q + AW'(1);
    if (pop_i)  rp_d = rp_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !rst) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign rdata_c = mem_q[rp_q];
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/uart_byte_fifo.sv
// Buffers received bytes and re-issues them as send pulses spaced one full
// UART frame apart so the transmitter is never handed a byte mid-frame.
module uart_byte_fifo
  import uart_byte_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned CLKDIV     = CLKDIV_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_fifo_if.slave bus
);

  localparam int unsigned PERIOD = CLKDIV * FRAME_BITS;
  localparam int unsigned GAP_W  = gap_width(PERIOD);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PERIOD - 1);

  logic       push_c;
  logic       pop_c;
  byte_t      fifo_rdata_c;
  logic       fifo_empty;
  logic       fifo_full;

  logic [GAP_W-1:0] gap_q, gap_d;
  byte_t            out_data_q, out_data_d;
  logic             out_send_q, out_send_d;
  logic             overflow_q, overflow_d;

  uart_byte_fifo_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (bus.in_data),
    .rdata_c (fifo_rdata_c),
    .count_o (bus.count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  always_comb begin
    gap_d      = gap_q;
    out_data_d = out_data_q;
    out_send_d = 1'b0;
    overflow_d = overflow_q;
    pop_c      = !fifo_empty && (gap_q == '0) && !out_send_q;
    push_c     = bus.in_valid && (!fifo_full || pop_c);
    if (pop_c) begin
      out_send_d = 1'b1;
      out_data_d = fifo_rdata_c;
      gap_d      = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
    if (bus.in_valid && fifo_full && !pop_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q      <= '0;
      out_data_q <= '0;
      out_send_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      out_send_q <= out_send_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_send = out_send_q;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo: cycle table for reset/single byte, then
// burst, overflow, full push+pop and mid-stream reset sequences.
module tb_uart_byte_fifo;
  import uart_byte_fifo_pkg::*;

  localparam int PERIOD = 320;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       send;
    logic [7:0] od;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_byte_fifo_if #(.DEPTH(16)) bus ();

  uart_byte_fifo #(.DEPTH(16), .CLKDIV(32), .FRAME_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         peak     = 0;
  logic [7:0] pdata[$];
  int         pcyc[$];
  vec_t       vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample #1 after the edge, log send pulses and peak occupancy.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_send) begin
      pdata.push_back(bus.out_data);
      pcyc.push_back(cyc);
    end
    if (int'(bus.count) > peak) peak = int'(bus.count);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (pdata.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, pdata.size(), n);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d,
                              input logic s, input logic [7:0] od, input int c,
                              input logic e, input logic f, input logic o);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.send = s; v.od = od;
    v.cnt = c; v.emp = e; v.ful = f; v.ovf = o;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c2;
    int t3;
    int cp;

    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;

    // rst iv data | send od cnt emp ful ovf
    vecs[0]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 0, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 8'h11, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 8'h22, 1'b0, 8'hA5, 2, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 2, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      rst          = vecs[i].rst;
      bus.in_valid = vecs[i].iv;
      bus.in_data  = vecs[i].d;
      step();
      check($sformatf("vec%0d out_send", i), int'(bus.out_send), int'(vecs[i].send));
      check($sformatf("vec%0d out_data", i), int'(bus.out_data), int'(vecs[i].od));
      check($sformatf("vec%0d count", i),    int'(bus.count),    vecs[i].cnt);
      check($sformatf("vec%0d empty", i),    int'(bus.empty),    int'(vecs[i].emp));
      check($sformatf("vec%0d full", i),     int'(bus.full),     int'(vecs[i].ful));
      check($sformatf("vec%0d overflow", i), int'(bus.overflow), int'(vecs[i].ovf));
    end
    bus.in_valid = 1'b0;
    repeat (400) step();
    check("single no extra pulse", pdata.size(), 1);

    // Burst of five bytes.
    reset_dut();
    base = pdata.size();
    peak = 0;
    for (int i = 0; i < 5; i++) push(8'(i + 1));
    wait_pulses(base + 5, 5 * PERIOD + 20, "burst pulse count");
    for (int i = 0; i < 5 && base + i < pdata.size(); i++) begin
      check($sformatf("burst data%0d", i), int'(pdata[base+i]), i + 1);
      if (i > 0) check($sformatf("burst gap%0d", i), pcyc[base+i] - pcyc[base+i-1], PERIOD);
    end
    check("burst peak count", peak, 4);
    repeat (400) step();
    check("burst no extra pulse", pdata.size(), base + 5);
    check("burst empty", int'(bus.empty), 1);

    // Eighteen back-to-back bytes: one pops early, one is dropped.
    reset_dut();
    base = pdata.size();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.in_data = 8'(8'h40 + i);
      step();
      if (i == 16) begin
        check("ovf count at 17th", int'(bus.count), 16);
        check("ovf not yet set", int'(bus.overflow), 0);
      end
      if (i == 17) begin
        check("ovf set after drop", int'(bus.overflow), 1);
        check("ovf full", int'(bus.full), 1);
        check("ovf count held", int'(bus.count), 16);
      end
    end
    bus.in_valid = 1'b0;
    wait_pulses(base + 17, 17 * PERIOD + 20, "ovf pulse count");
    for (int i = 0; i < 17 && base + i < pdata.size(); i++)
      check($sformatf("ovf data%0d", i), int'(pdata[base+i]), 8'h40 + i);
    repeat (400) step();
    check("ovf no extra pulse", pdata.size(), base + 17);
    check("ovf sticky", int'(bus.overflow), 1);

    // Fill to 16, then push on the exact cycle of the second pop.
    reset_dut();
    base = pdata.size();
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    check("simul count full", int'(bus.count), 16);
    check("simul no overflow", int'(bus.overflow), 0);
    c2 = (pcyc.size() > base) ? pcyc[base] : cyc;
    while (cyc < c2 + PERIOD - 1) step();
    push(8'hEE);
    check("simul second pop", pdata.size(), base + 2);
    check("simul count stays", int'(bus.count), 16);
    check("simul overflow stays", int'(bus.overflow), 0);
    wait_pulses(base + 18, 17 * PERIOD, "simul pulse count");
    if (pdata.size() >= base + 18) begin
      check("simul byte 17", int'(pdata[base+16]), 8'h90);
      check("simul accepted byte", int'(pdata[base+17]), 8'hEE);
    end

    // Reset in the middle of a six-byte burst.
    reset_dut();
    base = pdata.size();
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    wait_pulses(base + 3, 3 * PERIOD + 20, "midrst three pulses");
    t3 = (pcyc.size() >= base + 3) ? pcyc[base+2] : cyc;
    while (cyc < t3 + 100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst count", int'(bus.count), 0);
    check("midrst empty", int'(bus.empty), 1);
    check("midrst out_data", int'(bus.out_data), 0);
    repeat (700) step();
    check("midrst no more pulses", pdata.size(), base + 3);
    push(8'h3C);
    cp = cyc;
    wait_pulses(base + 4, 10, "midrst new pulse");
    if (pdata.size() >= base + 4) begin
      check("midrst new data", int'(pdata[base+3]), 8'h3C);
      check("midrst latency", pcyc[base+3] - cp, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
